// File: rtl/osd_overlay_ng.sv
// osd_overlay_ng: OSD overlay with a packed framebuffer, an RGB444 palette,
// explicit or auto-centred window placement and a fixed 3-ce_pix video pipeline.
// Build option: define OSD_SHADOW_EN to darken transparent pixels inside the window.
//
// Command FSM states
//   state      | meaning
//   IDLE       | no command frame open
//   CMD        | frame open, waiting for the command byte
//   WRITE_ADDR | waiting for framebuffer start address
//   WRITE_DATA | each word writes one framebuffer byte
//   PAL_IDX    | waiting for palette start index
//   PALETTE    | each word writes one palette entry
//   POS_X      | waiting for window x
//   POS_Y      | waiting for window y
//   SKIP       | remaining words ignored until io_osd drops
module osd_overlay_ng #(
  parameter int OSD_WIDTH  = 256,
  parameter int OSD_HEIGHT = 64,
  parameter int BPP        = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        io_osd,
  input  logic        io_strobe,
  input  logic [15:0] io_din,
  input  logic        ce_pix,
  input  logic [23:0] din,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [23:0] dout,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        osd_status
);
  localparam int DEPTH = OSD_WIDTH * OSD_HEIGHT * BPP / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int PPB   = 8 / BPP;
  localparam int SUBW  = $clog2(PPB);
  localparam int BPR   = OSD_WIDTH / PPB;
  localparam int NPAL  = 1 << BPP;

  typedef enum logic [3:0] {
    IDLE, CMD, WRITE_ADDR, WRITE_DATA, PAL_IDX, PALETTE, POS_X, POS_Y, SKIP
  } cmd_state_t;

  cmd_state_t state, state_nxt;
  logic strobe_q, stb;
  logic fb_we, addr_ld, pal_we, idx_ld, x_ld, y_ld, en_ld, auto_set;
  logic [AW-1:0] wr_addr;
  logic [BPP-1:0] pal_idx;
  logic [11:0] pos_x, pos_y;
  logic auto_c, en_pend, en_act;
  logic [11:0] pal [NPAL];
  logic unused_din;

  assign stb = io_strobe & ~strobe_q;
  assign unused_din = ^io_din[15:12];

  // Command state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Command decode: next state and one-cycle register-update strobes
  always_comb begin
    state_nxt = state;
    fb_we = 1'b0; addr_ld = 1'b0; pal_we = 1'b0; idx_ld = 1'b0;
    x_ld = 1'b0; y_ld = 1'b0; en_ld = 1'b0; auto_set = 1'b0;
    if (!io_osd) begin
      state_nxt = IDLE;
    end else if (stb) begin
      case (state)
        IDLE, CMD: begin
          case (io_din[7:0])
            8'h20:        state_nxt = WRITE_ADDR;
            8'h40, 8'h41: begin en_ld = 1'b1; state_nxt = SKIP; end
            8'h80:        state_nxt = PAL_IDX;
            8'hC0:        state_nxt = POS_X;
            8'hC1:        begin auto_set = 1'b1; state_nxt = SKIP; end
            default:      state_nxt = SKIP;
          endcase
        end
        WRITE_ADDR: begin addr_ld = 1'b1; state_nxt = WRITE_DATA; end
        WRITE_DATA: fb_we = 1'b1;
        PAL_IDX:    begin idx_ld = 1'b1; state_nxt = PALETTE; end
        PALETTE:    pal_we = 1'b1;
        POS_X:      begin x_ld = 1'b1; state_nxt = POS_Y; end
        POS_Y:      begin y_ld = 1'b1; state_nxt = SKIP; end
        default:    state_nxt = SKIP;
      endcase
    end else if (state == IDLE) begin
      state_nxt = CMD;
    end
  end

  // Bus-side configuration registers and palette
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      wr_addr  <= '0;
      pal_idx  <= '0;
      pos_x    <= '0;
      pos_y    <= '0;
      auto_c   <= 1'b1;
      en_pend  <= 1'b0;
      for (int i = 0; i < NPAL; i++) pal[i] <= (i == 0) ? 12'h000 : 12'hFFF;
    end else begin
      strobe_q <= io_strobe;
      if (addr_ld)    wr_addr <= io_din[AW-1:0];
      else if (fb_we) wr_addr <= (wr_addr == AW'(DEPTH - 1)) ? '0 : wr_addr + 1'b1;
      if (idx_ld) pal_idx <= io_din[BPP-1:0];
      else if (pal_we) begin
        if (pal_idx != '0) pal[pal_idx] <= io_din[11:0];
        pal_idx <= pal_idx + 1'b1;
      end
      // the x word alone is enough to leave auto-centre, so an aborted POS still moves x
      if (x_ld) begin pos_x <= io_din[11:0]; auto_c <= 1'b0; end
      if (y_ld) pos_y <= io_din[11:0];
      if (auto_set) auto_c <= 1'b1;
      if (en_ld) en_pend <= io_din[0];
    end
  end

  // Raster tracking; the rising edge pixel of de is column 0 and the line index is
  // the number of de rising edges seen earlier in the frame.
  logic de_q, vs_q, de_rise, de_fall, vs_rise;
  logic [11:0] h_cnt, v_cnt, v_line, width_last, lines_last, h_cur, v_cur;
  assign de_rise = de_in & ~de_q;
  assign de_fall = ~de_in & de_q;
  assign vs_rise = vs_in & ~vs_q;
  assign h_cur   = de_rise ? 12'd0 : h_cnt;
  assign v_cur   = de_rise ? v_cnt : v_line;

  // Raster counters, measured sizes and vsync-aligned enable
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      de_q <= 1'b0; vs_q <= 1'b0; en_act <= 1'b0;
      h_cnt <= '0; v_cnt <= '0; v_line <= '0; width_last <= '0; lines_last <= '0;
    end else if (ce_pix) begin
      de_q <= de_in;
      vs_q <= vs_in;
      if (de_in)   h_cnt <= h_cur + 12'd1;
      if (de_fall) width_last <= h_cnt;
      if (vs_rise) begin
        lines_last <= v_cnt;
        v_cnt      <= '0;
        en_act     <= en_pend;
      end else if (de_rise) begin
        v_cnt  <= v_cnt + 12'd1;
        v_line <= v_cnt;
      end
    end
  end

  // Window origin and hit test
  logic [11:0] x0, y0, rel_x, rel_y;
  logic [12:0] x_end, y_end;
  logic in_win;
  logic [AW-1:0] rd_addr;
  always_comb begin
    x0 = pos_x;
    y0 = pos_y;
    if (auto_c) begin
      x0 = (width_last >= 12'(OSD_WIDTH))  ? (width_last - 12'(OSD_WIDTH)) >> 1 : '0;
      y0 = (lines_last >= 12'(OSD_HEIGHT)) ? (lines_last - 12'(OSD_HEIGHT)) >> 1 : '0;
    end
    x_end  = {1'b0, x0} + 13'(OSD_WIDTH);
    y_end  = {1'b0, y0} + 13'(OSD_HEIGHT);
    in_win = de_in && (h_cur >= x0) && ({1'b0, h_cur} < x_end) &&
             (v_cur >= y0) && ({1'b0, v_cur} < y_end);
    rel_x  = h_cur - x0;
    rel_y  = v_cur - y0;
    rd_addr = in_win ? AW'(32'(rel_y) * BPR + 32'(rel_x >> SUBW)) : '0;
  end

  // Framebuffer: bus write port and pipeline read port, no reset
  logic [7:0] fb [DEPTH];
  logic [7:0] rd_byte;
  always_ff @(posedge clk_sys) begin
    if (fb_we && 32'(wr_addr) < DEPTH) fb[wr_addr] <= io_din[7:0];
    if (ce_pix) rd_byte <= fb[rd_addr];
  end

  function automatic logic [23:0] shade(input logic [23:0] c);
`ifdef OSD_SHADOW_EN
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
`else
    return c;
`endif
  endfunction

  logic [SUBW-1:0] s1_sub;
  logic s1_win, s2_win, s2_nz;
  logic [23:0] s1_din, s2_din, blend;
  logic [2:0] s1_sync, s2_sync;
  logic [11:0] s2_rgb;
  logic [BPP-1:0] pix_idx;
  assign pix_idx = BPP'(rd_byte >> (BPP * s1_sub));

  // Output select for the pixel leaving stage 2
  always_comb begin
    blend = s2_din;
    if (en_act && s2_win)
      blend = s2_nz ? {{2{s2_rgb[11:8]}}, {2{s2_rgb[7:4]}}, {2{s2_rgb[3:0]}}} : shade(s2_din);
  end

  // Three-stage pixel pipeline: RAM read, palette lookup, output mux
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_sub <= '0; s1_win <= 1'b0; s1_din <= '0; s1_sync <= '0;
      s2_rgb <= '0; s2_nz <= 1'b0; s2_win <= 1'b0; s2_din <= '0; s2_sync <= '0;
      dout <= '0; de_out <= 1'b0; hs_out <= 1'b0; vs_out <= 1'b0;
    end else if (ce_pix) begin
      s1_sub  <= rel_x[SUBW-1:0];
      s1_win  <= in_win;
      s1_din  <= din;
      s1_sync <= {de_in, hs_in, vs_in};
      s2_rgb  <= pal[pix_idx];
      s2_nz   <= (pix_idx != '0);
      s2_win  <= s1_win;
      s2_din  <= s1_din;
      s2_sync <= s1_sync;
      dout    <= blend;
      {de_out, hs_out, vs_out} <= s2_sync;
    end
  end

  assign osd_status = en_act;
endmodule

// File: tb/tb_osd_overlay_ng.sv
// Randomised bench for osd_overlay_ng on a small raster and a 16x6, 2 bpp window.
`timescale 1ns/1ps
module tb_osd_overlay_ng;
  localparam int OW = 16, OH = 6, BPP = 2;
  localparam int DEPTH = OW * OH * BPP / 8;
  localparam int PPB = 8 / BPP, NPAL = 1 << BPP;
  localparam int W = 40, LINES = 12, HB = 6, VB = 2;
  localparam int TW = W + HB, TL = LINES + VB;

  logic clk_sys = 1'b0, reset = 1'b1;
  logic io_osd = 1'b0, io_strobe = 1'b0;
  logic [15:0] io_din = '0;
  logic ce_pix = 1'b0, de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [23:0] din = '0;
  logic [23:0] dout;
  logic de_out, hs_out, vs_out, osd_status;

  always #5 clk_sys = ~clk_sys;

  osd_overlay_ng #(.OSD_WIDTH(OW), .OSD_HEIGHT(OH), .BPP(BPP)) dut (
    .clk_sys(clk_sys), .reset(reset), .io_osd(io_osd), .io_strobe(io_strobe),
    .io_din(io_din), .ce_pix(ce_pix), .din(din), .de_in(de_in), .hs_in(hs_in),
    .vs_in(vs_in), .dout(dout), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
    .osd_status(osd_status));

  // reference state
  logic [7:0]  m_fb [DEPTH];
  logic [11:0] m_pal [NPAL];
  int m_x, m_y, m_last_w, m_last_lines, m_lines;
  bit m_auto, m_en_pend, m_en_act;
  logic [26:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en_pend = 0; m_en_act = 0; m_auto = 1; m_x = 0; m_y = 0;
    m_last_w = 0; m_last_lines = 0; m_lines = 0;
    for (int i = 0; i < NPAL; i++) m_pal[i] = (i == 0) ? 12'h000 : 12'hFFF;
    exp_q.delete();
  endtask

  function automatic logic [23:0] exp_pix(input int x, input int y, input logic de,
                                          input logic [23:0] d);
    int x0, y0, lin, idx;
    logic [11:0] c;
    x0 = m_auto ? ((m_last_w >= OW) ? (m_last_w - OW) / 2 : 0) : m_x;
    y0 = m_auto ? ((m_last_lines >= OH) ? (m_last_lines - OH) / 2 : 0) : m_y;
    if (!(de && m_en_act && x >= x0 && x < x0 + OW && y >= y0 && y < y0 + OH)) return d;
    lin = (y - y0) * OW + (x - x0);
    idx = int'(m_fb[lin / PPB] >> (BPP * (lin % PPB))) & (NPAL - 1);
    if (idx == 0) begin
`ifdef OSD_SHADOW_EN
      return {1'b0, d[23:17], 1'b0, d[15:9], 1'b0, d[7:1]};
`else
      return d;
`endif
    end
    c = m_pal[idx];
    return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
  endfunction

  // monitor: the pixel sampled two ce edges ago is on the outputs after this ce edge
  initial begin
    logic ce_s;
    logic [26:0] e;
    forever begin
      @(posedge clk_sys);
      ce_s = ce_pix;
      #1;
      if (ce_s && !reset && exp_q.size() >= 3) begin
        e = exp_q.pop_front();
        check("video", {de_out, hs_out, vs_out, dout}, e);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // bus helpers
  task automatic bus_begin();
    @(negedge clk_sys); ce_pix = 1'b0; io_osd = 1'b1;
  endtask
  task automatic bus_word(input logic [15:0] w);
    @(negedge clk_sys); ce_pix = 1'b0; io_din = w; io_strobe = 1'b1;
    @(negedge clk_sys); io_strobe = 1'b0;
  endtask
  task automatic bus_end();
    @(negedge clk_sys); io_osd = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic cmd_write(input int addr, input int n, input bit fixed, input logic [7:0] fb);
    logic [7:0] b;
    int a = addr;
    bus_begin(); bus_word(16'h0020);
    bus_word({11'($urandom), 5'(addr)});
    for (int i = 0; i < n; i++) begin
      b = fixed ? fb : 8'($urandom);
      bus_word({8'($urandom), b});
      m_fb[a] = b;
      a = (a + 1) % DEPTH;
    end
    bus_end();
  endtask

  task automatic cmd_pal(input int idx, input int n, input bit fixed, input logic [11:0] fc);
    logic [11:0] c;
    int k = idx;
    bus_begin(); bus_word(16'h0080); bus_word(16'(idx));
    for (int i = 0; i < n; i++) begin
      c = fixed ? fc : 12'($urandom);
      bus_word({4'($urandom), c});
      if (k != 0) m_pal[k] = c;
      k = (k + 1) % NPAL;
    end
    bus_end();
  endtask

  task automatic cmd_enable(input bit b);
    bus_begin(); bus_word({8'h00, 7'h20, b}); bus_word(16'h00C1); bus_end();
    m_en_pend = b;
  endtask

  task automatic cmd_pos(input int x, input int y, input bit send_y);
    bus_begin(); bus_word(16'h00C0); bus_word({4'hA, 12'(x)});
    if (send_y) bus_word({4'h5, 12'(y)});
    bus_end();
    m_x = x; m_auto = 0;
    if (send_y) m_y = y;
  endtask

  task automatic cmd_center();
    bus_begin(); bus_word(16'h00C1); bus_word(16'h0000); bus_end();
    m_auto = 1;
  endtask

  task automatic cmd_unknown();
    bus_begin(); bus_word(16'h0033); bus_word(16'h0000); bus_word(16'h0055); bus_end();
  endtask

  task automatic pix(input logic de, input logic hs, input logic vs, input logic [23:0] d,
                     input int x, input int y);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk_sys);
      ce_pix = (t >= 3) || ($urandom_range(0, 3) != 0);
      de_in = de; hs_in = hs; vs_in = vs; din = d;
      @(posedge clk_sys);
      if (ce_pix) break;
    end
    exp_q.push_back({de, hs, vs, exp_pix(x, y, de, d)});
  endtask

  task automatic do_reset();
    @(negedge clk_sys); reset = 1'b1; #1;
    check("reset_dout", dout, 24'h0);
    check("reset_de", de_out, 1'b0);
    check("reset_hs", hs_out, 1'b0);
    check("reset_vs", vs_out, 1'b0);
    check("reset_status", osd_status, 1'b0);
    model_reset();
    ce_pix = 1'b0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
  endtask

  // one frame: vsync line, blank line, then active lines; optional mid-frame enable or reset
  task automatic run_frame(input bit fixed, input logic [23:0] fd, input int mid_en,
                           input int rst_line);
    bit act;
    m_en_act = m_en_pend;
    m_last_lines = m_lines;
    m_lines = 0;
    for (int l = 0; l < TL; l++) begin
      act = (l >= VB);
      if (l == VB + 4 && mid_en >= 0) begin
        cmd_enable(mid_en[0]);
        check("status_hold_mid_frame", osd_status, m_en_act);
      end
      for (int p = 0; p < TW; p++) begin
        if (l == rst_line && p == 10) begin
          do_reset();
          return;
        end
        pix(act && p < W, p >= W + 1 && p < W + 4, l == 0,
            fixed ? fd : 24'($urandom), p, l - VB);
      end
      if (act) begin
        m_last_w = W;
        m_lines++;
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (4) @(negedge clk_sys);
    check("init_dout", dout, 24'h0);
    check("init_status", osd_status, 1'b0);
    reset = 1'b0;

    run_frame(0, 0, -1, -1);
    cmd_write(0, DEPTH, 0, 0);
    cmd_pal(1, 3, 0, 0);
    cmd_pal(1, 1, 1, 12'hF00);
    cmd_write(0, 1, 1, 8'h55);
    cmd_enable(1);
    check("status_pending", osd_status, 1'b0);
    run_frame(0, 0, -1, -1);
    check("status_applied", osd_status, 1'b1);

    cmd_pal(3, 3, 0, 0);
    run_frame(0, 0, -1, -1);
    cmd_pos(5, 2, 1);
    run_frame(0, 0, -1, -1);
    cmd_pos(30, 9, 1);
    run_frame(0, 0, -1, -1);
    cmd_center();
    run_frame(0, 0, -1, -1);
    cmd_pos(1, 0, 0);
    cmd_pal(2, 1, 0, 0);
    run_frame(0, 0, -1, -1);
    cmd_pos(0, 0, 1);
    cmd_write(DEPTH - 1, 2, 0, 0);
    run_frame(0, 0, -1, -1);
    cmd_unknown();
    run_frame(1, 24'h808080, -1, -1);

    run_frame(0, 0, 0, -1);
    check("status_after_off_frame", osd_status, 1'b1);
    run_frame(0, 0, -1, -1);
    check("status_off", osd_status, 1'b0);
    run_frame(0, 0, 1, -1);
    check("status_still_off", osd_status, 1'b0);
    run_frame(0, 0, -1, -1);
    check("status_on_again", osd_status, 1'b1);

    run_frame(0, 0, -1, VB + 5);
    run_frame(1, 24'h123456, -1, -1);
    run_frame(0, 0, -1, -1);
    check("status_after_reset", osd_status, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/osd_overlay_ng.md
Name: osd_overlay_ng

Overview:
Parametrised next-generation OSD overlay. Sits between the core video output and the scaler/VGA path, and shares the HPS I/O command bus (io_osd/io_strobe/io_din).
- Holds a packed multi-bit-per-pixel framebuffer of configurable size.
- Maps pixels through a programmable RGB444 palette with a transparent index.
- Places the window at an explicit position or auto-centres it.
- Video passes through with fixed latency.
- Single clock domain: bus and video are both synchronous to clk_sys; ce_pix qualifies pixels.

Parameters:
OSD_WIDTH, 256, window width in pixels; multiple of 8/BPP.
OSD_HEIGHT, 64, window height in lines.
BPP, 2, bits per OSD pixel; legal values 1, 2, 4. Palette has 2^BPP entries.

Ports:
clk_sys  in  1  sole clock.
reset  in  1  asynchronous, active-high.
io_osd  in  1  command frame; high for the duration of one command.
io_strobe  in  1  word strobe; rising edge = one word.
io_din  in  16  command/data word.
ce_pix  in  1  pixel enable; video inputs are sampled and the pipeline advances only when high.
din  in  24  RGB888 input video.
de_in  in  1  data enable in.
hs_in  in  1  hsync in.
vs_in  in  1  vsync in.
dout  out  24  RGB888 output video.
de_out  out  1  delayed de_in.
hs_out  out  1  delayed hs_in.
vs_out  out  1  delayed vs_in.
osd_status  out  1  high while OSD is enabled and being displayed.

Behaviour:
- Reset values:
  - dout = 0; de_out/hs_out/vs_out = 0; osd_status = 0.
  - enable = 0; auto-centre on.
  - Palette: entry 0 = transparent; all other entries = RGB444 0xFFF.
  - Framebuffer contents undefined.
- Buffer:
  - DEPTH = OSD_WIDTH*OSD_HEIGHT*BPP/8 bytes, row-major.
  - Each byte holds 8/BPP pixels; leftmost pixel is in the LSBs.
- Command FSM states: IDLE, CMD, WRITE_ADDR, WRITE_DATA, PALETTE, POS_X, POS_Y.
  - io_osd low in any state returns the FSM to IDLE next clock. Words already received stay committed; the rest are discarded.
  - The first strobe in the frame is the command byte, io_din[7:0]:
    - 0x20 WRITE: next word = start byte address (io_din[15:0], truncated to the address width). Each following word writes io_din[7:0] and then increments the address; it wraps from DEPTH-1 to 0.
    - 0x40 ENABLE: bit0 = enable. No data words.
    - 0x80 PALETTE: next word = start index. Each following word writes RGB444 io_din[11:0], index auto-increments and wraps at 2^BPP. Writing index 0 leaves it transparent.
    - 0xC0 POS: next word = x (io_din[11:0]), then y (io_din[11:0]); auto-centre is cleared. Command 0xC1 sets auto-centre and takes no data words.
    - Unknown command: all words ignored until io_osd drops.
- Enable timing: a pending enable value is applied only at the next rising edge of vs_in, so the display never tears. osd_status follows the applied enable.
- Raster counters (advance on ce_pix only):
  - h_cnt clears on the de_in rising edge.
  - v_cnt increments on each de_in rising edge and clears on the vs_in rising edge.
  - The last line width and last frame line count are latched.
- Window placement:
  - Auto-centre: x0 = (width - OSD_WIDTH)>>1 and y0 = (lines - OSD_HEIGHT)>>1, computed from the previous line/frame. If the raster is smaller than the window, the result saturates to 0.
  - Window active when de_in && x0 <= h_cnt < x0+OSD_WIDTH && y0 <= v_cnt < y0+OSD_HEIGHT; the parts clipped by the raster are simply not shown.
- Pixel pipeline, one stage per ce_pix:
  - Stage 1: compute address and read RAM.
  - Stage 2: select pixel bits and look up the palette.
  - Stage 3: mux/blend.
  - Total latency is exactly 3 ce_pix for dout, de_out, hs_out and vs_out, with all four aligned.
- Output mux:
  - Inside the window with a non-zero index, and applied enable: dout = palette RGB444 expanded by nibble replication (e.g. 0xF80 gives FF,88,00).
  - Otherwise dout = din.
- Bus writes and video reads may hit the same address in the same clock. The read returns either old or new data; there is no stall and no corruption of the write.

Optional Feature:
OSD_SHADOW_EN
- Defined: inside the active window, transparent pixels (index 0) output din>>1 on each channel, darkening the background.
- Undefined: transparent pixels output din unchanged.
- Both builds keep the same latency and ports.

Test Plan:
- Reset mid-frame: assert reset during active video -> dout, de_out, hs_out, vs_out and osd_status are 0 immediately. After release, video passes through with 3-ce_pix latency and din=0x123456 gives dout=0x123456.
- Write and display, 640x480, BPP=2: 0x80 with idx 1 and word 0xF00; 0x20 with addr 0 and word 0x55; enable; auto-centre -> line y0=208 shows pixels x=192..195 as 0xFF0000, and the rest of the window passes din.
- POS command: x=10, y=20 -> first OSD pixel at h_cnt=10, v_cnt=20. A following 0xC1 re-centres on the next frame.
- Address wrap: WRITE start=DEPTH-1 with two data words -> bytes DEPTH-1 and 0 are written.
- Enable timing and abort: enable issued mid-frame -> osd_status rises only at the next vs_in rising edge. io_osd dropped after POS_X -> x is updated, y is unchanged, and the FSM is back in IDLE.
- OSD_SHADOW_EN build: transparent pixel in window with din=0x808080 -> dout=0x404040; outside the window dout=0x808080.
